qmr_fault_manager: RTL and testbench

QMR_FAULT_MANAGER -- requirements
Module: qmr_fault_manager

---
 rtl/qmr_fault_manager.sv | 209 ++++++++++++++++++++
 tb/tb_qmr_fault_manager.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module      : qmr_fault_manager
// Description : Fault bookkeeping and periodic self-test sequencer for a
//               5-ALU voted array.
//               - Samples the voter's per-ALU vote counts whenever the pipeline
//                 consumes a result (op_valid) or a self-test vector issues.
//               - Counts disagreements per ALU (err_cnt1..5) and
//                 no-majority events (nomaj_cnt). Both saturate.
//               - Quarantines an ALU once its count reaches ERR_THRESH.
//               - Raises a sticky fault_irq and flags fatal below 3 healthy ALUs.
//               - After TEST_PERIOD idle cycles, requests the array (test_req),
//                 waits for test_gnt, then drives one test vector (test_valid).
// Ports       : clk, reset            - clock, synchronous active-high reset
//               op_valid              - pipeline consumes a voted result
//               vote_cnt1..5          - per-ALU vote counts from the voter
//               clear_faults          - clears all fault state
//               test_gnt              - ALU array granted to the self-test
//               test_req/test_valid   - self-test handshake
//               test_a/b/alu_control  - self-test vector (zero when idle)
//               alu_quarantine        - bit i-1 set: ALUi quarantined
//               err_cnt1..5, nomaj_cnt- fault counters
//               healthy_count, fault_irq, fatal - health summary
// Revision    : 1.0 - initial release
// ============================================================================
module qmr_fault_manager #(
    parameter int N           = 64,
    parameter int CNT_W       = 8,
    parameter int ERR_THRESH  = 4,
    parameter int TEST_PERIOD = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       vote_cnt1,
    input  logic [2:0]       vote_cnt2,
    input  logic [2:0]       vote_cnt3,
    input  logic [2:0]       vote_cnt4,
    input  logic [2:0]       vote_cnt5,
    input  logic             clear_faults,
    input  logic             test_gnt,
    output logic             test_req,
    output logic             test_valid,
    output logic [N-1:0]     test_a,
    output logic [N-1:0]     test_b,
    output logic [3:0]       test_alu_control,
    output logic [4:0]       alu_quarantine,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [CNT_W-1:0] err_cnt3,
    output logic [CNT_W-1:0] err_cnt4,
    output logic [CNT_W-1:0] err_cnt5,
    output logic [CNT_W-1:0] nomaj_cnt,
    output logic [2:0]       healthy_count,
    output logic             fault_irq,
    output logic             fatal
);

    localparam int               c_TW        = $clog2(TEST_PERIOD + 1);
    localparam logic [c_TW-1:0]  c_PERIOD    = c_TW'(TEST_PERIOD);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
    // A threshold above the counter range can never be reached; guard the
    // truncated compare value so it cannot alias onto a smaller count.
    localparam bit               c_THR_OK    = (ERR_THRESH >= 1) &&
                                               (ERR_THRESH <= (2**CNT_W) - 1);
    localparam logic [CNT_W-1:0] c_THR_M1    = CNT_W'(ERR_THRESH - 1);
    localparam logic [N-1:0]     c_PAT_A     = N'({((N + 1) / 2){2'b10}});
    localparam logic [N-1:0]     c_PAT_B     = N'({((N + 1) / 2){2'b01}});

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;

    logic [2:0]       w_votes [5];
    logic             w_sample;
    logic             w_maj;
    logic [4:0]       w_inc;
    logic [4:0]       w_qset;
    logic [CNT_W-1:0] r_err [5];
    logic [4:0]       r_quar;
    logic [CNT_W-1:0] r_nomaj;
    logic             r_irq;
    logic [1:0]       r_state;
    logic [c_TW-1:0]  r_idle;
    logic [c_TW-1:0]  w_idle_next;
    logic [1:0]       r_vec_idx;
    logic             r_test_req;
    logic             r_test_valid;
    logic [3:0]       w_ctrl;
    logic [2:0]       w_qsum;

    assign w_votes[0] = vote_cnt1;
    assign w_votes[1] = vote_cnt2;
    assign w_votes[2] = vote_cnt3;
    assign w_votes[3] = vote_cnt4;
    assign w_votes[4] = vote_cnt5;

    // One sample per cycle even if a test vector and a pipeline op coincide.
    assign w_sample = op_valid | r_test_valid;
    assign w_maj    = (w_votes[0] >= 3'd3) | (w_votes[1] >= 3'd3) |
                      (w_votes[2] >= 3'd3) | (w_votes[3] >= 3'd3) |
                      (w_votes[4] >= 3'd3);

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_alu
            assign w_inc[gi]  = w_sample & w_maj & (w_votes[gi] < 3'd3) &
                                ~r_quar[gi] & (r_err[gi] != c_CNT_MAX);
            assign w_qset[gi] = w_inc[gi] & c_THR_OK & (r_err[gi] == c_THR_M1);

            always_ff @(posedge clk) begin
                if (reset || clear_faults) begin
                    r_err[gi]  <= '0;
                    r_quar[gi] <= 1'b0;
                end else begin
                    if (w_inc[gi])
                        r_err[gi] <= r_err[gi] + 1'b1;
                    if (w_qset[gi])
                        r_quar[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear_faults) begin
            r_nomaj <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_sample && !w_maj && (r_nomaj != c_CNT_MAX))
                r_nomaj <= r_nomaj + 1'b1;
            if ((w_sample && !w_maj) || (|w_qset))
                r_irq <= 1'b1;
        end
    end

    assign w_idle_next = op_valid ? '0 :
                         (r_idle == c_PERIOD) ? r_idle : r_idle + 1'b1;

    // Self-test sequencer; the idle timer and vector index ignore clear_faults.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_idle       <= '0;
            r_vec_idx    <= '0;
            r_test_req   <= 1'b0;
            r_test_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_idle <= w_idle_next;
                    if (r_idle == c_PERIOD) begin
                        r_state    <= c_ST_WAIT;
                        r_test_req <= 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    r_idle <= w_idle_next;
                    if (test_gnt) begin
                        r_state      <= c_ST_ISSUE;
                        r_test_req   <= 1'b0;
                        r_test_valid <= 1'b1;
                    end
                end
                c_ST_ISSUE: begin
                    r_state      <= c_ST_IDLE;
                    r_test_valid <= 1'b0;
                    r_idle       <= '0;
                    r_vec_idx    <= r_vec_idx + 1'b1;
                end
                default: begin
                    r_state      <= c_ST_IDLE;
                    r_test_req   <= 1'b0;
                    r_test_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_ctrl = 4'b0010;
        case (r_vec_idx)
            2'd0:    w_ctrl = 4'b0010;
            2'd1:    w_ctrl = 4'b0110;
            2'd2:    w_ctrl = 4'b0000;
            default: w_ctrl = 4'b0001;
        endcase
    end

    assign w_qsum = {2'b00, r_quar[0]} + {2'b00, r_quar[1]} + {2'b00, r_quar[2]} +
                    {2'b00, r_quar[3]} + {2'b00, r_quar[4]};

    assign test_req         = r_test_req;
    assign test_valid       = r_test_valid;
    assign test_a           = r_test_valid ? c_PAT_A : '0;
    assign test_b           = r_test_valid ? c_PAT_B : '0;
    assign test_alu_control = r_test_valid ? w_ctrl : 4'b0000;
    assign alu_quarantine   = r_quar;
    assign err_cnt1         = r_err[0];
    assign err_cnt2         = r_err[1];
    assign err_cnt3         = r_err[2];
    assign err_cnt4         = r_err[3];
    assign err_cnt5         = r_err[4];
    assign nomaj_cnt        = r_nomaj;
    assign healthy_count    = 3'd5 - w_qsum;
    assign fault_irq        = r_irq;
    assign fatal            = (healthy_count < 3'd3);

endmodule
`default_nettype wire

// File: tb/tb_qmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_qmr_fault_manager
// Description : Self-checking bench for qmr_fault_manager. Two instances with
//               different counter widths / thresholds / test periods share the
//               same stimulus; each is compared every cycle against its own
//               behavioural model. Directed scenarios pin literal values, then
//               a randomized phase runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qmr_fault_manager;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, op_valid, clear_faults, test_gnt;
    logic [2:0] v [5];

    logic          a_req, a_valid, a_irq, a_fatal, b_req, b_valid, b_irq, b_fatal;
    logic [N-1:0]  a_ta, a_tb, b_ta, b_tb;
    logic [3:0]    a_ctrl, b_ctrl;
    logic [4:0]    a_q, b_q;
    logic [2:0]    a_h, b_h;
    logic [7:0]    a_e1, a_e2, a_e3, a_e4, a_e5, a_nm;
    logic [2:0]    b_e1, b_e2, b_e3, b_e4, b_e5, b_nm;

    qmr_fault_manager #(.N(N), .CNT_W(8), .ERR_THRESH(4), .TEST_PERIOD(8)) u_a (
        .clk(clk), .reset(reset), .op_valid(op_valid),
        .vote_cnt1(v[0]), .vote_cnt2(v[1]), .vote_cnt3(v[2]), .vote_cnt4(v[3]), .vote_cnt5(v[4]),
        .clear_faults(clear_faults), .test_gnt(test_gnt),
        .test_req(a_req), .test_valid(a_valid), .test_a(a_ta), .test_b(a_tb),
        .test_alu_control(a_ctrl), .alu_quarantine(a_q),
        .err_cnt1(a_e1), .err_cnt2(a_e2), .err_cnt3(a_e3), .err_cnt4(a_e4), .err_cnt5(a_e5),
        .nomaj_cnt(a_nm), .healthy_count(a_h), .fault_irq(a_irq), .fatal(a_fatal));

    qmr_fault_manager #(.N(N), .CNT_W(3), .ERR_THRESH(8), .TEST_PERIOD(5)) u_b (
        .clk(clk), .reset(reset), .op_valid(op_valid),
        .vote_cnt1(v[0]), .vote_cnt2(v[1]), .vote_cnt3(v[2]), .vote_cnt4(v[3]), .vote_cnt5(v[4]),
        .clear_faults(clear_faults), .test_gnt(test_gnt),
        .test_req(b_req), .test_valid(b_valid), .test_a(b_ta), .test_b(b_tb),
        .test_alu_control(b_ctrl), .alu_quarantine(b_q),
        .err_cnt1(b_e1), .err_cnt2(b_e2), .err_cnt3(b_e3), .err_cnt4(b_e4), .err_cnt5(b_e5),
        .nomaj_cnt(b_nm), .healthy_count(b_h), .fault_irq(b_irq), .fatal(b_fatal));

    // Gather both instances' outputs into indexable arrays.
    logic [7:0]   d_err [2][5];
    logic [7:0]   d_nm [2];
    logic [N-1:0] d_ta [2];
    logic [N-1:0] d_tb [2];
    logic [3:0]   d_ctrl [2];
    logic [4:0]   d_q [2];
    logic [2:0]   d_h [2];
    logic [1:0]   d_req, d_valid, d_irq, d_fatal;
    assign d_err[0][0] = a_e1; assign d_err[0][1] = a_e2; assign d_err[0][2] = a_e3;
    assign d_err[0][3] = a_e4; assign d_err[0][4] = a_e5;
    assign d_err[1][0] = {5'd0, b_e1}; assign d_err[1][1] = {5'd0, b_e2};
    assign d_err[1][2] = {5'd0, b_e3}; assign d_err[1][3] = {5'd0, b_e4};
    assign d_err[1][4] = {5'd0, b_e5};
    assign d_nm[0] = a_nm;     assign d_nm[1] = {5'd0, b_nm};
    assign d_ta[0] = a_ta;     assign d_ta[1] = b_ta;
    assign d_tb[0] = a_tb;     assign d_tb[1] = b_tb;
    assign d_ctrl[0] = a_ctrl; assign d_ctrl[1] = b_ctrl;
    assign d_q[0] = a_q;       assign d_q[1] = b_q;
    assign d_h[0] = a_h;       assign d_h[1] = b_h;
    assign d_req = {b_req, a_req};
    assign d_valid = {b_valid, a_valid};
    assign d_irq = {b_irq, a_irq};
    assign d_fatal = {b_fatal, a_fatal};

    // Behavioural model state, one slot per instance.
    int       P_CMAX [2] = '{255, 7};
    int       P_THR  [2] = '{4, 8};
    int       P_PER  [2] = '{8, 5};
    int       CTRL   [4] = '{2, 6, 0, 1};
    int       m_err [2][5];
    int       m_nm [2];
    bit [4:0] m_q [2];
    bit       m_irq [2];
    int       m_idle [2];
    bit       m_req [2];
    bit       m_iss [2];
    int       m_vec [2];

    logic [N-1:0] PAT_A = {32{2'b10}};
    logic [N-1:0] PAT_B = {32{2'b01}};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int k, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        bit sample, maj;
        int nidle;
        sample = op_valid || m_iss[k];
        maj = 1'b0;
        for (int i = 0; i < 5; i++) if (v[i] >= 3) maj = 1'b1;
        if (reset) begin
            for (int i = 0; i < 5; i++) m_err[k][i] = 0;
            m_nm[k] = 0; m_q[k] = '0; m_irq[k] = 0;
            m_idle[k] = 0; m_req[k] = 0; m_iss[k] = 0; m_vec[k] = 0;
            return;
        end
        if (clear_faults) begin
            for (int i = 0; i < 5; i++) m_err[k][i] = 0;
            m_nm[k] = 0; m_q[k] = '0; m_irq[k] = 0;
        end else if (sample) begin
            if (!maj) begin
                if (m_nm[k] < P_CMAX[k]) m_nm[k]++;
                m_irq[k] = 1;
            end else begin
                for (int i = 0; i < 5; i++)
                    if (v[i] < 3 && !m_q[k][i] && m_err[k][i] < P_CMAX[k]) begin
                        m_err[k][i]++;
                        if (m_err[k][i] == P_THR[k]) begin
                            m_q[k][i] = 1; m_irq[k] = 1;
                        end
                    end
            end
        end
        nidle = op_valid ? 0 : ((m_idle[k] < P_PER[k]) ? m_idle[k] + 1 : P_PER[k]);
        if (m_iss[k]) begin
            m_iss[k] = 0; m_idle[k] = 0; m_vec[k] = (m_vec[k] + 1) % 4;
        end else if (m_req[k]) begin
            if (test_gnt) begin m_req[k] = 0; m_iss[k] = 1; end
            m_idle[k] = nidle;
        end else begin
            if (m_idle[k] == P_PER[k]) m_req[k] = 1;
            m_idle[k] = nidle;
        end
    endtask

    task automatic model_cmp(input int k);
        int qn;
        qn = $countones(m_q[k]);
        for (int i = 0; i < 5; i++) chk($sformatf("err_cnt%0d", i + 1), k, N'(d_err[k][i]), N'(m_err[k][i]));
        chk("nomaj_cnt", k, N'(d_nm[k]), N'(m_nm[k]));
        chk("quarantine", k, N'(d_q[k]), N'(m_q[k]));
        chk("fault_irq", k, N'(d_irq[k]), N'(m_irq[k]));
        chk("healthy", k, N'(d_h[k]), N'(5 - qn));
        chk("fatal", k, N'(d_fatal[k]), N'((5 - qn) < 3));
        chk("test_req", k, N'(d_req[k]), N'(m_req[k]));
        chk("test_valid", k, N'(d_valid[k]), N'(m_iss[k]));
        chk("test_a", k, d_ta[k], m_iss[k] ? PAT_A : '0);
        chk("test_b", k, d_tb[k], m_iss[k] ? PAT_B : '0);
        chk("test_ctrl", k, N'(d_ctrl[k]), m_iss[k] ? N'(CTRL[m_vec[k]]) : '0);
    endtask

    // Inputs are set by the caller before this; outputs are checked on the
    // falling edge that follows the active edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        model_cmp(0);
        model_cmp(1);
    endtask

    task automatic setv(input int a, input int b, input int c, input int d, input int e);
        v[0] = 3'(a); v[1] = 3'(b); v[2] = 3'(c); v[3] = 3'(d); v[4] = 3'(e);
    endtask

    task automatic do_reset();
        reset = 1; op_valid = 0; clear_faults = 0; test_gnt = 0;
        cycle();
        reset = 0;
    endtask

    initial begin
        reset = 1; op_valid = 0; clear_faults = 0; test_gnt = 0;
        setv(4, 4, 4, 4, 4);
        @(negedge clk);
        do_reset();
        chk("rst_healthy", 0, N'(a_h), N'(5));
        chk("rst_fatal", 0, N'(a_fatal), '0);
        chk("rst_req", 0, N'(a_req), '0);
        chk("rst_valid", 0, N'(a_valid), '0);

        // Fault accumulation on ALU1.
        op_valid = 1; setv(2, 4, 4, 4, 4);
        for (int j = 0; j < 4; j++) begin
            cycle();
            chk("acc_err1", 0, N'(a_e1), N'(j + 1));
        end
        chk("acc_quar", 0, N'(a_q), N'(5'b00001));
        chk("acc_irq", 0, N'(a_irq), N'(1));
        chk("acc_healthy", 0, N'(a_h), N'(4));

        // No majority.
        do_reset();
        op_valid = 1; setv(2, 2, 1, 2, 2);
        cycle();
        chk("nomaj_cnt_lit", 0, N'(a_nm), N'(1));
        chk("nomaj_err1", 0, N'(a_e1), '0);
        chk("nomaj_irq", 0, N'(a_irq), N'(1));

        // Fatal then clear, clear beating a same-cycle disagreement.
        do_reset();
        op_valid = 1; setv(2, 2, 2, 4, 4);
        repeat (4) cycle();
        chk("fatal_quar", 0, N'(a_q), N'(5'b00111));
        chk("fatal_h", 0, N'(a_h), N'(2));
        chk("fatal_lit", 0, N'(a_fatal), N'(1));
        clear_faults = 1; setv(4, 4, 4, 2, 4);
        cycle();
        clear_faults = 0;
        chk("clr_quar", 0, N'(a_q), '0);
        chk("clr_err4", 0, N'(a_e4), '0);
        chk("clr_err1", 0, N'(a_e1), '0);
        chk("clr_fatal", 0, N'(a_fatal), '0);

        // Self-test request, grant and vector sequence.
        do_reset();
        op_valid = 0; setv(4, 4, 4, 4, 4);
        repeat (8) cycle();
        chk("st_req_early", 0, N'(a_req), '0);
        cycle();
        chk("st_req", 0, N'(a_req), N'(1));
        op_valid = 1;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("st_req_hold", 0, N'(a_req), N'(1));
        end
        op_valid = 0; test_gnt = 1;
        cycle();
        test_gnt = 0;
        chk("st_valid", 0, N'(a_valid), N'(1));
        chk("st_ctrl0", 0, N'(a_ctrl), N'(4'b0010));
        chk("st_a", 0, a_ta, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("st_b", 0, a_tb, 64'h5555_5555_5555_5555);
        cycle();
        chk("st_valid_off", 0, N'(a_valid), '0);
        chk("st_a_off", 0, a_ta, '0);
        repeat (9) cycle();
        test_gnt = 1;
        cycle();
        test_gnt = 0;
        chk("st_ctrl1", 0, N'(a_ctrl), N'(4'b0110));

        // Saturation on the 3-bit instance; idle restart on instance A.
        do_reset();
        op_valid = 1; setv(4, 2, 4, 4, 4);
        for (int j = 0; j < 9; j++) begin
            cycle();
            chk("sat_err2", 1, N'(b_e2), N'((j + 1 < 7) ? j + 1 : 7));
        end
        chk("sat_quar", 1, N'(b_q), '0);
        do_reset();
        op_valid = 0;
        repeat (7) cycle();
        op_valid = 1;
        cycle();
        op_valid = 0;
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk("idle_noreq", 0, N'(a_req), '0);
        end

        // Reset during ISSUE aborts the sample.
        do_reset();
        op_valid = 0; setv(4, 4, 4, 4, 4);
        repeat (9) cycle();
        test_gnt = 1;
        cycle();
        chk("abort_issue", 0, N'(a_valid), N'(1));
        test_gnt = 0; reset = 1; setv(2, 4, 4, 4, 4);
        cycle();
        reset = 0;
        chk("abort_valid", 0, N'(a_valid), '0);
        chk("abort_err1", 0, N'(a_e1), '0);

        // Randomized phase with varying op_valid density.
        for (int blk = 0; blk < 20; blk++) begin
            int dens;
            dens = $urandom_range(0, 9);
            for (int c = 0; c < 150; c++) begin
                int mode;
                reset        = ($urandom_range(0, 199) == 0);
                clear_faults = ($urandom_range(0, 39) == 0);
                op_valid     = ($urandom_range(0, 9) < dens);
                test_gnt     = ($urandom_range(0, 2) == 0);
                mode = $urandom_range(0, 9);
                if (mode < 3) begin
                    for (int i = 0; i < 5; i++) v[i] = 3'($urandom_range(0, 5));
                end else begin
                    int bad;
                    bad = $urandom_range(0, 6);
                    for (int i = 0; i < 5; i++) v[i] = (i == bad) ? 3'd1 : 3'd4;
                end
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
